// File: rtl/ysyx_22050710_pkg.sv
// Shared definitions for the ysyx_22050710 core: widths and write-back stage states.
package ysyx_22050710_pkg;

    localparam int XLEN       = 64;
    localparam int NR_REG     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int CSR_ADDR_W = 12;

    // Write-back stage run state; HALT is left only through reset.
    typedef enum logic {
        WBU_RUN  = 1'b0,
        WBU_HALT = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/ysyx_22050710_regfile.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports and a fixed x10 tap. x0 is hard-wired to zero.
module ysyx_22050710_regfile
    import ysyx_22050710_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NR_REG = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wen,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr1,
    input  logic [REG_IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]      o_rdata1,
    output logic [XLEN-1:0]      o_rdata2,
    output logic [XLEN-1:0]      o_x10
);

    logic [XLEN-1:0] regs [NR_REG];

    // Synchronous clear of the whole array; otherwise write any register but x0.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != '0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    // Combinational reads; x0 forced to zero regardless of array contents.
    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : regs[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : regs[i_raddr2];
        o_x10    = regs[10];
    end

endmodule

// File: rtl/ysyx_22050710_wbu.sv
// Write-back stage: holds one completed record for a single cycle and commits it
// (GPR write, CSR write port, retired-instruction count, halt on ebreak).
module ysyx_22050710_wbu
    import ysyx_22050710_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NR_REG = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // Handshake: a record transfers at a rising edge where i_valid and o_ready
    // are both 1. o_ready does not depend on i_valid, and the LSU must hold the
    // record stable while i_valid=1 and o_ready=0.
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [XLEN-1:0]       i_pc,
    input  logic [31:0]           i_inst,
    input  logic [REG_IDX_W-1:0]  i_rd,
    input  logic                  i_rf_wen,
    input  logic [XLEN-1:0]       i_rf_wdata,
    input  logic                  i_csr_wen,
    input  logic [CSR_ADDR_W-1:0] i_csr_waddr,
    input  logic [XLEN-1:0]       i_csr_wdata,
    input  logic                  i_ebreak,
    input  logic [REG_IDX_W-1:0]  i_rs1,
    input  logic [REG_IDX_W-1:0]  i_rs2,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    output logic                  o_csr_wen,
    output logic [CSR_ADDR_W-1:0] o_csr_waddr,
    output logic [XLEN-1:0]       o_csr_wdata,
    output logic                  o_commit_valid,
    output logic [XLEN-1:0]       o_commit_pc,
    output logic [31:0]           o_commit_inst,
    output logic [XLEN-1:0]       o_instret,
    output logic                  o_halted,
    output logic [XLEN-1:0]       o_a0,
    output wbu_state_e            o_dbg_state
);

    wbu_state_e state_q;
    wbu_state_e state_d;

    logic                  ent_valid;
    logic [XLEN-1:0]       ent_pc;
    logic [31:0]           ent_inst;
    logic [REG_IDX_W-1:0]  ent_rd;
    logic                  ent_rf_wen;
    logic [XLEN-1:0]       ent_rf_wdata;
    logic                  ent_csr_wen;
    logic [CSR_ADDR_W-1:0] ent_csr_waddr;
    logic [XLEN-1:0]       ent_csr_wdata;
    logic                  ent_ebreak;

    logic [XLEN-1:0]       instret_q;
    logic                  accept;
    logic                  rf_wen;
    logic [XLEN-1:0]       rf_rdata1;
    logic [XLEN-1:0]       rf_rdata2;
    logic [XLEN-1:0]       rf_x10;

    assign accept = i_valid & o_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= WBU_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt once an ebreak record has committed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WBU_RUN:  if (ent_valid && ent_ebreak) state_d = WBU_HALT;
            WBU_HALT: state_d = WBU_HALT;
            default:  state_d = WBU_RUN;
        endcase
    end

    // FSM outputs: ready is withdrawn while an ebreak commits so nothing follows it.
    always_comb begin
        o_ready     = (state_q == WBU_RUN) & ~(ent_valid & ent_ebreak) & i_rst;
        o_halted    = (state_q == WBU_HALT);
        o_dbg_state = state_q;
    end

    // Stage entry: the entry always commits in its cycle, so valid simply follows accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ent_valid     <= 1'b0;
            ent_pc        <= '0;
            ent_inst      <= '0;
            ent_rd        <= '0;
            ent_rf_wen    <= 1'b0;
            ent_rf_wdata  <= '0;
            ent_csr_wen   <= 1'b0;
            ent_csr_waddr <= '0;
            ent_csr_wdata <= '0;
            ent_ebreak    <= 1'b0;
        end else begin
            ent_valid <= accept;
            if (accept) begin
                ent_pc        <= i_pc;
                ent_inst      <= i_inst;
                ent_rd        <= i_rd;
                ent_rf_wen    <= i_rf_wen;
                ent_rf_wdata  <= i_rf_wdata;
                ent_csr_wen   <= i_csr_wen;
                ent_csr_waddr <= i_csr_waddr;
                ent_csr_wdata <= i_csr_wdata;
                ent_ebreak    <= i_ebreak;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 2^XLEN.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            instret_q <= '0;
        end else if (ent_valid) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    // A commit coinciding with reset is dropped, so gate the array write with i_rst.
    assign rf_wen = ent_valid & ent_rf_wen & i_rst;

    ysyx_22050710_regfile #(
        .XLEN   (XLEN),
        .NR_REG (NR_REG)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wen    (rf_wen),
        .i_waddr  (ent_rd),
        .i_wdata  (ent_rf_wdata),
        .i_raddr1 (i_rs1),
        .i_raddr2 (i_rs2),
        .o_rdata1 (rf_rdata1),
        .o_rdata2 (rf_rdata2),
        .o_x10    (rf_x10)
    );

    // Read bypass: the committing entry is visible to readers in its own cycle.
    always_comb begin
        o_rs1_data = rf_rdata1;
        o_rs2_data = rf_rdata2;
        o_a0       = rf_x10;
        if (ent_valid && ent_rf_wen && (ent_rd != '0)) begin
            if (ent_rd == i_rs1)                o_rs1_data = ent_rf_wdata;
            if (ent_rd == i_rs2)                o_rs2_data = ent_rf_wdata;
            if (ent_rd == REG_IDX_W'(10))       o_a0       = ent_rf_wdata;
        end
    end

    // Commit-side outputs come straight from the entry.
    always_comb begin
        o_commit_valid = ent_valid;
        o_commit_pc    = ent_pc;
        o_commit_inst  = ent_inst;
        o_csr_wen      = ent_csr_wen & ent_valid;
        o_csr_waddr    = ent_csr_waddr;
        o_csr_wdata    = ent_csr_wdata;
        o_instret      = instret_q;
    end

endmodule

// File: tb/tb_ysyx_22050710_wbu.sv
// Bench for the write-back stage: driver tasks issue records, an expected-commit
// queue is checked by a negedge monitor against an architectural register model.
module tb_ysyx_22050710_wbu;
    import ysyx_22050710_pkg::*;

    localparam int W = 244;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_pc;
    logic [31:0] i_inst;
    logic [4:0]  i_rd;
    logic        i_rf_wen;
    logic [63:0] i_rf_wdata;
    logic        i_csr_wen;
    logic [11:0] i_csr_waddr;
    logic [63:0] i_csr_wdata;
    logic        i_ebreak;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [63:0] o_rs1_data;
    logic [63:0] o_rs2_data;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata;
    logic        o_commit_valid;
    logic [63:0] o_commit_pc;
    logic [31:0] o_commit_inst;
    logic [63:0] o_instret;
    logic        o_halted;
    logic [63:0] o_a0;
    wbu_state_e  o_dbg_state;

    // clock / reset
    always #5 i_clk = ~i_clk;

    ysyx_22050710_wbu dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_pc           (i_pc),
        .i_inst         (i_inst),
        .i_rd           (i_rd),
        .i_rf_wen       (i_rf_wen),
        .i_rf_wdata     (i_rf_wdata),
        .i_csr_wen      (i_csr_wen),
        .i_csr_waddr    (i_csr_waddr),
        .i_csr_wdata    (i_csr_wdata),
        .i_ebreak       (i_ebreak),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .o_rs1_data     (o_rs1_data),
        .o_rs2_data     (o_rs2_data),
        .o_csr_wen      (o_csr_wen),
        .o_csr_waddr    (o_csr_waddr),
        .o_csr_wdata    (o_csr_wdata),
        .o_commit_valid (o_commit_valid),
        .o_commit_pc    (o_commit_pc),
        .o_commit_inst  (o_commit_inst),
        .o_instret      (o_instret),
        .o_halted       (o_halted),
        .o_a0           (o_a0),
        .o_dbg_state    (o_dbg_state)
    );

    // scoreboard and architectural model
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [63:0] gpr_m [32];
    logic [63:0] instret_m;
    logic        halted_m;
    logic        ebreak_acc;
    logic        mon_en;
    logic [63:0] pc_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) gpr_m[i] = '0;
        instret_m  = '0;
        halted_m   = 1'b0;
        ebreak_acc = 1'b0;
    endtask

    // driver: called #1 after a rising edge, returns #1 after the next one
    task automatic send(input logic v, input logic [4:0] rd, input logic rfw,
                        input logic [63:0] wd, input logic cw, input logic [11:0] ca,
                        input logic [63:0] cd, input logic eb,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        logic exp_rdy;
        logic acc;
        logic [31:0] inst;
        inst        = $urandom;
        i_valid     = v;
        i_pc        = pc_cnt;
        i_inst      = inst;
        i_rd        = rd;
        i_rf_wen    = rfw;
        i_rf_wdata  = wd;
        i_csr_wen   = cw;
        i_csr_waddr = ca;
        i_csr_wdata = cd;
        i_ebreak    = eb;
        i_rs1       = rs1;
        i_rs2       = rs2;
        @(negedge i_clk);
        exp_rdy = i_rst & ~ebreak_acc;
        chk("ready", o_ready, exp_rdy);
        acc = v & exp_rdy;
        @(posedge i_clk);
        if (acc) begin
            exp_q.push_back({pc_cnt, inst, rd, rfw, wd, cw, ca, cd, eb});
            if (eb) ebreak_acc = 1'b1;
            pc_cnt = pc_cnt + 64'd4;
        end
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        send(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 12'd0, 64'd0, 1'b0, rs1, rs2);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_rst   = 1'b0;
        @(posedge i_clk);
        clear_model();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    // monitor: every record accepted at edge E must commit in cycle E..E+1
    logic [W-1:0] m_e;
    logic [63:0]  m_pc;
    logic [31:0]  m_inst;
    logic [4:0]   m_rd;
    logic         m_rfw;
    logic [63:0]  m_wd;
    logic         m_cw;
    logic [11:0]  m_ca;
    logic [63:0]  m_cd;
    logic         m_eb;
    logic         m_commit;

    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("halted", o_halted, halted_m);
            chk("dbg_state", (o_dbg_state == WBU_HALT), halted_m);
            chk("instret", o_instret, instret_m);
            m_commit = (exp_q.size() != 0);
            if (m_commit) begin
                m_e = exp_q.pop_front();
                {m_pc, m_inst, m_rd, m_rfw, m_wd, m_cw, m_ca, m_cd, m_eb} = m_e;
                chk("commit_valid", o_commit_valid, 1'b1);
                chk("commit_pc", o_commit_pc, m_pc);
                chk("commit_inst", o_commit_inst, m_inst);
                chk("csr_wen", o_csr_wen, m_cw);
                if (m_cw) begin
                    chk("csr_waddr", o_csr_waddr, m_ca);
                    chk("csr_wdata", o_csr_wdata, m_cd);
                end
                if (i_rst && m_rfw && m_rd != 5'd0) gpr_m[m_rd] = m_wd;
            end else begin
                chk("commit_valid", o_commit_valid, 1'b0);
                chk("csr_wen", o_csr_wen, 1'b0);
            end
            if (i_rst) begin
                chk("rs1_data", o_rs1_data, gpr_m[i_rs1]);
                chk("rs2_data", o_rs2_data, gpr_m[i_rs2]);
                chk("a0", o_a0, gpr_m[10]);
                if (m_commit) begin
                    instret_m = instret_m + 64'd1;
                    if (m_eb) halted_m = 1'b1;
                end
            end
        end
    end

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_pc = '0; i_inst = '0; i_rd = '0;
        i_rf_wen = 1'b0; i_rf_wdata = '0; i_csr_wen = 1'b0; i_csr_waddr = '0;
        i_csr_wdata = '0; i_ebreak = 1'b0; i_rs1 = '0; i_rs2 = '0;
        mon_en = 1'b0;
        pc_cnt = 64'h8000_0000;
        clear_model();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst  = 1'b1;
        mon_en = 1'b1;

        // reset state
        i_rs1 = 5'd10; i_rs2 = 5'd31;
        @(negedge i_clk);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_instret", o_instret, 64'd0);
        chk("rst_a0", o_a0, 64'd0);
        chk("rst_commit", o_commit_valid, 1'b0);
        chk("rst_rs2", o_rs2_data, 64'd0);
        @(posedge i_clk);
        #1;

        // write then read through bypass, then from the array
        send(1'b1, 5'd5, 1'b1, 64'h1234, 1'b0, 12'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd5);

        // x0 write is dropped but still retires
        send(1'b1, 5'd0, 1'b1, 64'hFFFF, 1'b0, 12'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // back-to-back overwrite of x3
        send(1'b1, 5'd3, 1'b1, 64'hA, 1'b0, 12'd0, 64'd0, 1'b0, 5'd3, 5'd3);
        send(1'b1, 5'd3, 1'b1, 64'hB, 1'b0, 12'd0, 64'd0, 1'b0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // CSR write without GPR write
        send(1'b1, 5'd9, 1'b0, 64'hDEAD, 1'b1, 12'h305, 64'h8000_0000, 1'b0, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            send(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 31)), 1'($urandom),
                 {$urandom, $urandom}, 1'($urandom), 12'($urandom),
                 {$urandom, $urandom}, 1'b0,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // halt: x10=0 then ebreak, later records are refused
        send(1'b1, 5'd10, 1'b1, 64'd0, 1'b0, 12'd0, 64'd0, 1'b0, 5'd10, 5'd10);
        send(1'b1, 5'd0, 1'b0, 64'd0, 1'b0, 12'd0, 64'd0, 1'b1, 5'd10, 5'd10);
        for (int n = 0; n < 5; n++) begin
            send(1'b1, 5'($urandom_range(1, 31)), 1'b1, {$urandom, $urandom}, 1'b1,
                 12'h300, 64'd1, 1'b0, 5'd10, 5'($urandom_range(0, 31)));
        end
        @(negedge i_clk);
        chk("halt_halted", o_halted, 1'b1);
        chk("halt_a0", o_a0, 64'd0);
        chk("halt_ready", o_ready, 1'b0);
        @(posedge i_clk);
        #1;

        // reset clears the halt
        do_reset();
        idle(5'd1, 5'd2);

        // reset during the commit cycle of x7=0x55
        send(1'b1, 5'd7, 1'b1, 64'h55, 1'b0, 12'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        do_reset();
        i_rs1 = 5'd7; i_rs2 = 5'd7;
        @(negedge i_clk);
        chk("rstc_x7", o_rs1_data, 64'd0);
        chk("rstc_instret", o_instret, 64'd0);
        chk("rstc_halted", o_halted, 1'b0);
        chk("rstc_ready", o_ready, 1'b1);
        @(posedge i_clk);
        #1;

        // a little traffic after reset
        for (int n = 0; n < 20; n++) begin
            send(1'b1, 5'($urandom_range(0, 31)), 1'b1, {$urandom, $urandom}, 1'b0,
                 12'd0, 64'd0, 1'b0, 5'($urandom_range(0, 31)), 5'd7);
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // report
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_wbu.md
# ysyx_22050710_wbu

Write-back stage of the ysyx_22050710 core, directly downstream of the load/store unit. It holds one completed instruction record (final GPR data selected by the LSU, CSR write data, PC, instruction word) for one cycle, then commits it:
- writes the general-purpose register file it owns;
- drives the CSR write port;
- increments the retired-instruction counter;
- stops the core on `ebreak`.

## Interface
Parameters:
- `XLEN`, 64, data/PC width.
- `NR_REG`, 32, GPR count; index width is log2(`NR_REG`) = 5.

Ports:
- `i_clk` in 1 — single clock; everything is on the rising edge.
- `i_rst` in 1 — reset: synchronous, active-low.
- `i_valid` in 1 — LSU presents a completed record.
- `o_ready` out 1 — WBU accepts a record this cycle.
- `i_pc` in 64 — PC of record.
- `i_inst` in 32 — instruction word.
- `i_rd` in 5 — destination GPR index.
- `i_rf_wen` in 1 — GPR write requested.
- `i_rf_wdata` in 64 — GPR write data (LSU result mux output).
- `i_csr_wen` in 1 — CSR write requested.
- `i_csr_waddr` in 12 — CSR address.
- `i_csr_wdata` in 64 — CSR write data.
- `i_ebreak` in 1 — record is `ebreak`.
- `i_rs1`, `i_rs2` in 5 each — decode-stage read indices.
- `o_rs1_data`, `o_rs2_data` out 64 each — read data, with bypass.
- `o_csr_wen`, `o_csr_waddr` (12), `o_csr_wdata` (64) out — CSR write port, valid in commit cycle.
- `o_commit_valid` out 1 — a record commits this cycle.
- `o_commit_pc` out 64, `o_commit_inst` out 32 — committing record, for difftest/trace.
- `o_instret` out 64 — retired-instruction count.
- `o_halted` out 1 — core stopped by `ebreak`.
- `o_a0` out 64 — current x10, for good/bad trap check.

## Operation
- One-entry stage register: `ent_valid` plus all record fields.
- FSM states:
  - **RUN** → **HALT** when an `ebreak` entry commits.
  - **HALT** → **RUN** only by reset.
- Accept: on `i_valid & o_ready`, capture all fields and set `ent_valid`=1.
- Commit: the cycle in which `ent_valid`=1.
  - `o_commit_valid`=1; `o_commit_pc`/`o_commit_inst`/`o_csr_*` are driven combinationally from the entry.
  - `o_csr_wen` = `ent_csr_wen & ent_valid`.
  - At the end-of-cycle edge:
    - GPR[rd] ← data if `rf_wen` and rd≠0;
    - `instret` += 1;
    - `ent_valid` ← 0 unless a new record is accepted in the same cycle.
- `o_ready` = (state==RUN) & !(`ent_valid` & `ent_ebreak`) & `i_rst`.
  - Gives one record per cycle throughput.
  - The entry never stalls, because commit always completes in one cycle.
- The `ebreak` entry itself commits normally (its own GPR/CSR writes are honoured, `instret` counts it). The state then becomes HALT: `o_ready`=0 and `o_halted`=1 thereafter.
- x0:
  - reads always return 0;
  - writes to x0 are dropped.
  - The bypass never forwards for rd=0.
- Read ports are combinational. If `ent_valid & ent_rf_wen & ent_rd≠0 & ent_rd==i_rsN`, return `ent_rf_wdata`; otherwise return the array value.
- `o_a0` applies the same bypass with index 10.
- `instret` wraps modulo 2^64 with no saturation.

## Timing
- Record accepted at edge E: committing during cycle E..E+1, and architecturally visible in the array from edge E+1.
- Through the bypass, readers see the data during cycle E..E+1 (zero-bubble).
- `o_csr_*` are valid in the same commit cycle; the CSR file writes at edge E+1.
- Reset (`i_rst`=0 at an edge) sets:
  - `ent_valid`=0, state=RUN, `instret`=0;
  - all GPRs=0.
  - During reset cycles, `o_ready`=0.
  - Outputs after reset: `o_commit_valid`=0, `o_csr_wen`=0, `o_halted`=0, `o_instret`=0, `o_a0`=0, read data 0.
- Reset during a commit cycle: the pending entry is discarded, with no GPR write and no `instret` increment.
- Simultaneous commit of entry N and accept of N+1: both happen at the same edge.

## Structure
- Shared package `ysyx_22050710_pkg` holds:
  - `XLEN`, `NR_REG`, `REG_IDX_W`, `CSR_ADDR_W`;
  - WBU state constants `WBU_RUN`, `WBU_HALT`.
- One sub-module: `ysyx_22050710_regfile` — 32×64 array, one synchronous write port, two combinational read ports plus an x10 tap, synchronous active-low clear.
- Bypass and FSM stay in the WBU.

## Test plan
- **Write then read:** accept rd=5, data=0x1234, `rf_wen`=1.
  - In the commit cycle, `i_rs1`=5 returns 0x1234 via the bypass.
  - One cycle later it returns 0x1234 from the array; `o_instret`=1.
- **x0 write:** write rd=0, data=0xFFFF → `i_rs2`=0 reads 0 in every cycle; `instret` still increments.
- **Back-to-back overwrite:** records x3=0xA then x3=0xB on consecutive cycles.
  - `o_ready` stays 1.
  - Reads of x3 give 0xA in the first commit cycle and 0xB in the second.
  - `instret`=2.
- **CSR write:** `csr_wen`=1, addr=0x305, data=0x8000_0000 → `o_csr_wen` pulses exactly one cycle with those values; no GPR change when `rf_wen`=0.
- **Halt:** x10=0 written, then an `ebreak` record.
  - `ebreak` commits (`o_commit_valid`=1) and `o_ready` drops in that cycle.
  - From the next cycle, `o_halted`=1 and `o_a0`=0.
  - Further `i_valid` is ignored; `instret` stays frozen.
- **Reset mid-commit:** assert `i_rst`=0 in the commit cycle of x7=0x55.
  - After release: x7 reads 0, `instret`=0, `o_halted`=0, `o_ready`=1.
